// File: rtl/findmax_pkg.sv
// Shared constants and result record layout for the findMax datapath.
package findmax_pkg;

  localparam int unsigned FINDMAX_DATA_W = 8;
  localparam int unsigned FINDMAX_IDX_W  = 8;

  typedef struct packed {
    logic [FINDMAX_DATA_W-1:0] max;
    logic [FINDMAX_IDX_W-1:0]  idx;
    logic [FINDMAX_IDX_W-1:0]  cnt;
    logic                      sat;
  } findmax_res_t;

  localparam int unsigned FINDMAX_RES_W = $bits(findmax_res_t);

endpackage

// File: rtl/findmax_if.sv
// Result bus from the findMax datapath to its downstream consumer (valid/ready).
interface findmax_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 8
);

  logic [DATA_W-1:0] res_max;
  logic [IDX_W-1:0]  res_idx;
  logic [IDX_W-1:0]  res_cnt;
  logic              res_sat;
  logic              res_valid;
  logic              res_ready;
  logic              res_ovr;

  modport master (
    output res_max, res_idx, res_cnt, res_sat, res_valid, res_ovr,
    input  res_ready
  );

  modport slave (
    input  res_max, res_idx, res_cnt, res_sat, res_valid, res_ovr,
    output res_ready
  );

endinterface

// File: rtl/findmax_res_buf.sv
// One-entry valid/ready holding register for a flat result record,
// with overwrite-on-load and a sticky overrun flag.
module findmax_res_buf #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] rec_in,
  input  logic         ready,
  output logic [W-1:0] rec_out,
  output logic         valid,
  output logic         ovr
);

  logic [W-1:0] rec_q, rec_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;

  always_comb begin
    rec_d   = rec_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    // A load wins over a same-cycle accept; only an unaccepted record counts as overrun.
    if (load) begin
      rec_d   = rec_in;
      valid_d = 1'b1;
      if (valid_q && !ready) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rec_q   <= rec_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rec_out = rec_q;
  assign valid   = valid_q;
  assign ovr     = ovr_q;

endmodule

// File: rtl/findmax_datapath.sv
// Running-maximum datapath for the findMax FSM: compare, max/index registers,
// sample counter and result capture. FINDMAX_SIGNED_EN selects signed compare.
module findmax_datapath
  import findmax_pkg::*;
#(
  parameter int unsigned DATA_W = FINDMAX_DATA_W,
  parameter int unsigned IDX_W  = FINDMAX_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  input  logic              ldMax,
  input  logic              done,
  output logic              in_GTR_Max,
  findmax_if.master         res
);

  localparam int unsigned REC_W = DATA_W + 2 * IDX_W + 1;

  logic [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [IDX_W-1:0]  idx_cnt_q, idx_cnt_d;
  logic              sat_q, sat_d;
  logic              active_q, active_d;
  logic              first;
  logic [IDX_W-1:0]  cur_idx;
  logic [REC_W-1:0]  rec_in, rec_out;

`ifdef FINDMAX_SIGNED_EN
  assign in_GTR_Max = $signed(data_in) > $signed(max_q);
`else
  assign in_GTR_Max = data_in > max_q;
`endif

  always_comb begin
    active_d  = start;
    first     = start && !active_q;
    cur_idx   = first ? '0 : idx_cnt_q;
    idx_cnt_d = idx_cnt_q;
    sat_d     = sat_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    // Counter holds at all-ones; the sample that would overflow it flags saturation.
    if (first) begin
      idx_cnt_d = IDX_W'(1);
      sat_d     = 1'b0;
    end else if (start) begin
      if (&idx_cnt_q) begin
        sat_d = 1'b1;
      end else begin
        idx_cnt_d = idx_cnt_q + 1'b1;
      end
    end
    if (ldMax && start) begin
      max_d     = data_in;
      max_idx_d = cur_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q     <= '0;
      max_idx_q <= '0;
      idx_cnt_q <= '0;
      sat_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      idx_cnt_q <= idx_cnt_d;
      sat_q     <= sat_d;
      active_q  <= active_d;
    end
  end

  assign rec_in = {max_q, max_idx_q, idx_cnt_q, sat_q};

  findmax_res_buf #(
    .W (REC_W)
  ) u_res_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (done),
    .rec_in  (rec_in),
    .ready   (res.res_ready),
    .rec_out (rec_out),
    .valid   (res.res_valid),
    .ovr     (res.res_ovr)
  );

  assign res.res_max = rec_out[REC_W-1 -: DATA_W];
  assign res.res_idx = rec_out[2*IDX_W -: IDX_W];
  assign res.res_cnt = rec_out[IDX_W -: IDX_W];
  assign res.res_sat = rec_out[0];

endmodule

// File: doc/findmax_datapath.md
# findmax_datapath

Datapath stage paired with the findMax control FSM. It holds the running maximum and its sample index, and drives `in_GTR_Max` back to the FSM. It acts on the FSM's `ldMax` and `done` strobes. On `done` it captures a result record (max, index, count) into a one-entry valid/ready output buffer for the downstream consumer.

## Interface
- `DATA_W`, 8: width of input samples and stored maximum.
- `IDX_W`, 8: width of sample index and sample count.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `data_in` input DATA_W: sample presented each cycle `start` is high.
- `start` input 1: session active; one sample per cycle while high.
- `ldMax` input 1: FSM strobe to load `data_in` into the max register.
- `done` input 1: FSM strobe marking end of session.
- `in_GTR_Max` output 1: combinational, `data_in` > stored max.
- `res_max` output DATA_W: captured maximum.
- `res_idx` output IDX_W: index of the captured maximum within its session (first sample = 0).
- `res_cnt` output IDX_W: number of samples in the captured session.
- `res_sat` output 1: session exceeded 2^IDX_W−1 samples; count/index saturated.
- `res_valid` output 1: result buffer holds an unconsumed record.
- `res_ready` input 1: consumer accepts the record when high with `res_valid`.
- `res_ovr` output 1: sticky; a record was overwritten before it was consumed.

## Operation
- Internal state: `max_reg`, `max_idx`, `idx_cnt`, `sat`, `active` flag.
- `active` <= `start` every cycle. The first sample of a session is a cycle with `start && !active`.
- First sample: `idx_cnt` <= 1, `sat` <= 0. The loaded index is 0.
- Subsequent samples with `start` high: `idx_cnt` increments. At all-ones it holds and `sat` <= 1.
- Current sample index is 0 on the first sample, otherwise `idx_cnt`.
- Load: when `ldMax && start`, `max_reg` <= `data_in` and `max_idx` <= current sample index.
- `ldMax` with `start` low is ignored. The FSM may assert it on the `done` cycle.
- Comparison is unsigned and strict (`>`). Ties keep the earliest index.
- `in_GTR_Max` is driven from `data_in` vs `max_reg` in all cycles, including idle.
- Capture on `done`: the result buffer loads {`max_reg`, `max_idx`, `idx_cnt`, `sat`} as they are in that cycle, and `res_valid` <= 1.
- Handshake: `res_valid && res_ready` clears `res_valid` unless `done` is also high that cycle.
- `done` with `res_valid && res_ready`: the new record loads, `res_valid` stays 1, and `res_ovr` is unchanged.
- `done` with `res_valid && !res_ready`: the record is overwritten and `res_ovr` <= 1.
- `res_ovr` is cleared only by reset.
- Outputs are stable while `res_valid && !res_ready`.

## Timing
- Reset (async assert, sync to `clk` on release): all registers 0, so every `res_*` output is 0, `res_valid` 0 and `res_ovr` 0.
- `in_GTR_Max` follows `max_reg`, which is 0 at reset.
- `in_GTR_Max` has zero latency (combinational). A `max_reg` update is visible the cycle after `ldMax`.
- Result latency: `res_valid` rises in the cycle after `done`.
- A back-to-back session (`start` low one cycle, then high) is legal. The new session's first load does not disturb the buffered record.
- `rst_n` asserted mid-session or with `res_valid` high clears everything. No record is produced.

## Configuration
- `FINDMAX_SIGNED_EN` defined: `data_in`, `max_reg` and `res_max` are treated as two's-complement. The comparison is signed, and the reset value of `max_reg` stays 0.
- Not defined: unsigned comparison.
- No other behaviour changes.

## Structure
- `findmax_pkg` holds:
  - default `DATA_W`/`IDX_W` constants;
  - `findmax_res_t` packed struct {max, idx, cnt, sat}.
- Sub-module `findmax_res_buf`: one-entry valid/ready holding register with overwrite and sticky overrun logic, parameterised on the record type width.
- Top level holds compare, max/index registers and counters.

## Test plan
- **Basic session.** Reset, then samples 3,9,4,9,2 with the FSM driving `ldMax`/`done`, `res_ready`=1. Expect `res_max`=9, `res_idx`=1, `res_cnt`=5, `res_valid` for 1 cycle.
- **Spurious load.** `ldMax`=1 with `start`=0 and `data_in`=200 on the `done` cycle. Expect `max_reg` unchanged and the record max equal to the prior max.
- **Overrun.** Two sessions (7,1 then 5) with `res_ready`=0. Expect a record of {5,0,1}, `res_ovr`=1. Then `res_ready`=1 clears `res_valid` and `res_ovr` stays 1.
- **Simultaneous done and accept.** Expect the new record loaded, `res_valid` continuous and `res_ovr`=0.
- **Saturation.** IDX_W=3, 10 samples with the max at position 9. Expect `res_cnt`=7, `res_idx`=7, `res_sat`=1.
- **Reset mid-session.** Assert `rst_n`=0 after 2 samples. Expect all outputs 0 and no record. Then with `FINDMAX_SIGNED_EN`, session −5,−2,−9: expect `res_max`=−2, `res_idx`=1.
